// File: rtl/multicycle_ctrl_if.sv
// Decoder, datapath and memory-port signals of the multi-cycle controller.
// The master drives decoder and memory inputs; the slave is the controller.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             RegWrite_i;
  logic [1:0]       ResultSrc_i;
  logic             MemWrite_i;
  logic             Jump_i;
  logic             Branch_i;
  logic             illegal_i;
  logic             branch_taken_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             AdrSrc_o;
  logic             IRWrite_o;
  logic             PCWrite_o;
  logic             PCSrc_o;
  logic             RegWriteEn_o;
  logic             retire_o;
  logic             halt_o;
  logic [1:0]       trap_cause_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output RegWrite_i, ResultSrc_i, MemWrite_i, Jump_i, Branch_i, illegal_i,
           branch_taken_i, mem_ready_i,
    input  mem_req_o, mem_we_o, AdrSrc_o, IRWrite_o, PCWrite_o, PCSrc_o,
           RegWriteEn_o, retire_o, halt_o, trap_cause_o, state_o, instret_o
  );

  modport slave (
    input  RegWrite_i, ResultSrc_i, MemWrite_i, Jump_i, Branch_i, illegal_i,
           branch_taken_i, mem_ready_i,
    output mem_req_o, mem_we_o, AdrSrc_o, IRWrite_o, PCWrite_o, PCSrc_o,
           RegWriteEn_o, retire_o, halt_o, trap_cause_o, state_o, instret_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: shared memory-port handshake, bus watchdog,
// retirement counting and trap/halt reporting.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_ctrl_if.slave bus
);
  localparam logic [1:0] RESSRC_MEM = 2'b01;
  localparam int WD_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT == 0) ? '0 : WD_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t           state;
  logic [WD_W-1:0]  wd;
  logic [1:0]       cause;
  logic [CNT_W-1:0] instret;

  logic mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_we, retire;
  logic is_ls, wd_expire;

  assign is_ls     = (bus.ResultSrc_i == RESSRC_MEM) || bus.MemWrite_i;
  assign wd_expire = (MEM_TIMEOUT != 0) && !bus.mem_ready_i && (wd == WD_LAST);

  // Enables follow the same-cycle inputs; reset forces every one low at once,
  // so an in-flight request is dropped without waiting for a clock edge.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    adr_src  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    reg_we   = 1'b0;
    retire   = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = bus.mem_ready_i;
        end
        S_EXEC: begin
          if (bus.Jump_i) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            reg_we   = bus.RegWrite_i;
            retire   = 1'b1;
          end else if (bus.Branch_i) begin
            pc_write = 1'b1;
            pc_src   = bus.branch_taken_i;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          mem_we  = bus.MemWrite_i;
          if (bus.mem_ready_i && bus.MemWrite_i) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          reg_we   = bus.RegWrite_i;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_FETCH;
      wd      <= '0;
      cause   <= 2'b00;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + 1'b1;
      case (state)
        S_FETCH, S_MEM: begin
          if (bus.mem_ready_i) begin
            wd <= '0;
            if (state == S_FETCH)       state <= S_DECODE;
            else if (bus.MemWrite_i)    state <= S_FETCH;
            else                        state <= S_WB;
          end else if (wd_expire) begin
            wd    <= '0;
            cause <= 2'b10;
            state <= S_TRAP;
          end else if (MEM_TIMEOUT != 0) begin
            wd <= wd + 1'b1;
          end
        end
        S_DECODE: begin
          if (bus.illegal_i) begin
            cause <= 2'b01;
            state <= S_TRAP;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.Jump_i || bus.Branch_i) state <= S_FETCH;
          else if (is_ls)                 state <= S_MEM;
          else                            state <= S_WB;
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.AdrSrc_o     = adr_src;
  assign bus.IRWrite_o    = ir_write;
  assign bus.PCWrite_o    = pc_write;
  assign bus.PCSrc_o      = pc_src;
  assign bus.RegWriteEn_o = reg_we;
  assign bus.retire_o     = retire;
  assign bus.halt_o       = (state == S_TRAP);
  assign bus.trap_cause_o = cause;
  assign bus.state_o      = state;
  assign bus.instret_o    = instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from
// the instruction-class timing rules, compared cycle by cycle.
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus();
  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int exp_instret = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  bit          rdy_q[$];

  // {state, req, we, adr, irw, pcw, pcs, rwe, retire, halt, cause}
  function automatic logic [13:0] v(input logic [2:0] st, input bit req, we, adr, irw,
                                    pcw, pcs, rwe, ret, hlt, input logic [1:0] cause);
    return {st, req, we, adr, irw, pcw, pcs, rwe, ret, hlt, cause};
  endfunction

  function automatic logic [13:0] sample();
    return {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.AdrSrc_o, bus.IRWrite_o,
            bus.PCWrite_o, bus.PCSrc_o, bus.RegWriteEn_o, bus.retire_o, bus.halt_o,
            bus.trap_cause_o};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [13:0] e, input bit r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  task automatic trap_tail(input logic [1:0] c);
    for (int i = 0; i < 4; i++) push(v(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, c), rnd());
  endtask

  // Reference trace: fw/mw are wait cycles before ready in FETCH/MEM.
  task automatic build(input int kind, input bit rw, input bit tk, input int fw, input int mw);
    bit st;
    st = (kind == K_STORE);
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < fw && i < TO; i++) push(v(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    if (fw >= TO) begin trap_tail(2'b10); return; end
    push(v(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1);
    push(v(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
    if (kind == K_ILL) begin trap_tail(2'b01); return; end
    if (kind == K_JMP) begin push(v(3'd2, 0, 0, 0, 0, 1, 1, rw, 1, 0, 0), rnd()); return; end
    if (kind == K_BR)  begin push(v(3'd2, 0, 0, 0, 0, 1, tk, 0, 1, 0, 0), rnd()); return; end
    push(v(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
    if (kind == K_LOAD || st) begin
      for (int i = 0; i < mw && i < TO; i++) push(v(3'd3, 1, st, 1, 0, 0, 0, 0, 0, 0, 0), 0);
      if (mw >= TO) begin trap_tail(2'b10); return; end
      push(v(3'd3, 1, st, 1, 0, st, 0, 0, st, 0, 0), 1);
      if (st) return;
    end
    push(v(3'd4, 0, 0, 0, 0, 1, 0, rw, 1, 0, 0), rnd());
  endtask

  // Decoder flags for a class; lower-priority flags are randomly set where
  // a higher-priority one must win.
  task automatic set_dec(input int kind, input bit rw, input bit tk);
    logic [1:0] rs;
    rs = 2'($urandom_range(0, 3));
    bus.Jump_i         = (kind == K_JMP);
    bus.Branch_i       = (kind == K_BR) || (kind == K_JMP && rnd());
    bus.MemWrite_i     = (kind == K_STORE) || ((kind == K_JMP || kind == K_BR) && rnd());
    bus.RegWrite_i     = rw;
    bus.branch_taken_i = tk;
    bus.illegal_i      = (kind == K_ILL);
    if (kind == K_LOAD) rs = 2'b01;
    else if (kind == K_STORE || kind == K_ILL) rs = 2'b00;
    else if (kind == K_ALU && rs == 2'b01) rs = 2'b10;
    bus.ResultSrc_i = rs;
  endtask

  task automatic drive(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mem_ready_i = rdy_q[i];
      #2 obs_q.push_back(sample());
    end
  endtask

  task automatic run_instr(input int kind, input bit rw, input bit tk, input int fw, input int mw);
    set_dec(kind, rw, tk);
    build(kind, rw, tk, fw, mw);
    drive(exp_q.size());
    foreach (exp_q[i]) exp_instret += int'(exp_q[i][3]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_reset();
    bus.RegWrite_i = 0; bus.ResultSrc_i = 0; bus.MemWrite_i = 0; bus.Jump_i = 0;
    bus.Branch_i = 0; bus.illegal_i = 0; bus.branch_taken_i = 0; bus.mem_ready_i = 1;
    #12;
    tests++;
    if (sample() !== 14'd0) begin fails++; $display("FAIL reset_outputs got=%b want=0", sample()); end
    tests++;
    if (bus.instret_o !== 32'd0) begin fails++; $display("FAIL reset_instret got=%0d want=0", bus.instret_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    #1;
    tests++;
    if (bus.mem_req_o !== 1'b1 || bus.state_o !== 3'd0) begin
      fails++; $display("FAIL first_request req=%b state=%0d want req=1 state=0", bus.mem_req_o, bus.state_o);
    end
    exp_instret = 0;
  endtask

  task automatic test_alu();
    run_instr(K_ALU, 1, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL addi cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (bus.instret_o !== 32'(exp_instret)) begin fails++; $display("FAIL addi_instret got=%0d want=%0d", bus.instret_o, exp_instret); end
  endtask

  task automatic test_load_wait();
    run_instr(K_LOAD, 1, 0, 0, 3);
    tests++;
    if (exp_q.size() != 8 || obs_q.size() != 8) begin fails++; $display("FAIL lw_latency got=%0d want=8", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL lw cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_branches();
    for (int b = 0; b < 2; b++) begin
      run_instr(K_BR, 1, (b == 0), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL branch%0d cyc%0d got=%b want=%b", b, i, obs_q[i], exp_q[i]); end
      end
    end
    tests++;
    if (bus.instret_o !== 32'(exp_instret)) begin fails++; $display("FAIL branch_instret got=%0d want=%0d", bus.instret_o, exp_instret); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(K_ALU, K_JMP);
      run_instr(kind, rnd(), rnd(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d kind%0d cyc%0d got=%b want=%b", n, kind, i, obs_q[i], exp_q[i]); end
      end
      tests++;
      if (bus.instret_o !== 32'(exp_instret)) begin fails++; $display("FAIL rand%0d_instret got=%0d want=%0d", n, bus.instret_o, exp_instret); end
    end
  endtask

  task automatic test_illegal();
    run_instr(K_ILL, 1, 0, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL illegal cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    rst = 1'b1;
    #1;
    tests++;
    if (sample() !== 14'd0 || bus.instret_o !== 32'd0) begin
      fails++; $display("FAIL illegal_reset got=%b instret=%0d want all 0", sample(), bus.instret_o);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(K_ALU, 1, 0, TO, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL fetch_timeout cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    do_reset();
    run_instr(K_ALU, 1, 0, TO - 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL fetch_ready_last cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    run_instr(K_LOAD, 1, 0, 0, TO);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL mem_timeout cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    run_instr(K_ALU, 1, 0, 0, 0);
    run_instr(K_JMP, 1, 0, 1, 0);
    tests++;
    if (bus.instret_o !== 32'(exp_instret)) begin fails++; $display("FAIL pre_sw_instret got=%0d want=%0d", bus.instret_o, exp_instret); end
    set_dec(K_STORE, 0, 0);
    build(K_STORE, 0, 0, 0, 3);
    drive(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL sw_prefix cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (sample() !== 14'd0 || bus.instret_o !== 32'd0) begin
      fails++; $display("FAIL mid_mem_reset got=%b instret=%0d want all 0", sample(), bus.instret_o);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    exp_instret = 0;
    #1;
    tests++;
    if (bus.mem_req_o !== 1'b1 || bus.state_o !== 3'd0 || bus.retire_o !== 1'b0) begin
      fails++; $display("FAIL post_reset_fetch req=%b state=%0d ret=%b want 1/0/0", bus.mem_req_o, bus.state_o, bus.retire_o);
    end
    run_instr(K_STORE, 0, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL sw_after_reset cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (bus.instret_o !== 32'(exp_instret)) begin fails++; $display("FAIL sw_instret got=%0d want=%0d", bus.instret_o, exp_instret); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branches();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core; consumes the main decoder's control outputs and drives per-cycle datapath enables.
- One shared memory port serves instruction fetch and data access; this block owns the request/ready handshake on that port and a bus-timeout watchdog.
- Sits between the decoder and the datapath's PC, IR, register file and memory-address mux.
- Reports retirement, halt and trap cause.

Parameters:
- MEM_TIMEOUT, 16: max consecutive unanswered request cycles before a bus trap; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, asynchronous, active-high.
- RegWrite_i in 1: decoder register-write request.
- ResultSrc_i in 2: decoder result source; `RESSRC_MEM marks a load.
- MemWrite_i in 1: decoder store flag.
- Jump_i in 1: JAL/JALR.
- Branch_i in 1: conditional branch.
- illegal_i in 1: opcode unsupported (top-level decode of op).
- branch_taken_i in 1: comparison result from the ALU; valid in EXECUTE.
- mem_ready_i in 1: memory completes the current request.
- mem_req_o out 1: memory request.
- mem_we_o out 1: write strobe; valid with mem_req_o.
- AdrSrc_o out 1: memory address select; 0 = PC, 1 = ALU result.
- IRWrite_o out 1: latch instruction register.
- PCWrite_o out 1: update PC.
- PCSrc_o out 1: next-PC select; 0 = PC+4, 1 = branch/jump target.
- RegWriteEn_o out 1: register file write enable.
- retire_o out 1: one-cycle pulse when an instruction completes.
- halt_o out 1: core halted, sticky.
- trap_cause_o out 2: 00 none, 01 illegal opcode, 10 bus timeout.
- state_o out 3: current state, for debug.
- instret_o out CNT_W: retired-instruction count.

Behaviour:
- Reset (async, immediate, including mid-handshake):
  - state = FETCH.
  - All outputs 0, including mem_req_o, instret_o and trap_cause_o.
  - Watchdog counter cleared.
  - First request is issued in the first cycle after rst_i deasserts.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7. Outputs not listed for a state are 0.
- FETCH:
  - mem_req_o=1, AdrSrc_o=0, mem_we_o=0.
  - On mem_ready_i=1: IRWrite_o=1 in that cycle, then go to DECODE. Otherwise stay.
- DECODE (1 cycle): illegal_i=1 -> TRAP with cause 01; else -> EXECUTE.
- EXECUTE (1 cycle):
  - Load or store: -> MEM.
  - Branch: PCWrite_o=1, PCSrc_o=branch_taken_i, retire_o=1, -> FETCH.
  - Jump: PCWrite_o=1, PCSrc_o=1, RegWriteEn_o=RegWrite_i, retire_o=1, -> FETCH.
  - Otherwise (ALU, LUI, AUIPC): -> WB.
  - Priority if several flags are set: Jump > Branch > load/store > ALU.
- MEM:
  - mem_req_o=1, AdrSrc_o=1, mem_we_o=MemWrite_i.
  - Wait for mem_ready_i.
  - Store: on ready, PCWrite_o=1, PCSrc_o=0, retire_o=1, -> FETCH.
  - Load: on ready, -> WB; the datapath captures read data on that ready cycle.
- WB (1 cycle): RegWriteEn_o=RegWrite_i, PCWrite_o=1, PCSrc_o=0, retire_o=1, -> FETCH.
- Handshake rules:
  - mem_req_o, AdrSrc_o and mem_we_o are held stable until the ready cycle.
  - mem_ready_i is ignored when mem_req_o=0.
  - mem_req_o deasserts in the cycle after ready.
- Watchdog:
  - Counts consecutive FETCH/MEM cycles with ready low; cleared on state entry and on ready.
  - If the MEM_TIMEOUT-th consecutive cycle also has ready low, go to TRAP with cause 10.
  - Ready arriving on that same cycle wins; no trap.
  - MEM_TIMEOUT=0 disables the watchdog.
- TRAP:
  - halt_o=1, trap_cause_o held, mem_req_o=0.
  - No enables asserted; remains until reset.
- instret_o increments on every retire_o pulse and wraps modulo 2^CNT_W.
- Latency with zero-wait memory (ready in the first request cycle):
  - branch/jump: 3 cycles.
  - ALU/LUI/AUIPC: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds 1 cycle.

Test Plan:
- ADDI, ready always 1 -> states 0,1,2,4 then 0; RegWriteEn_o and retire_o high in cycle 4 only; instret_o=1.
- LW with ready delayed 3 cycles in MEM -> mem_req_o and AdrSrc_o held high for 4 cycles, then WB with RegWriteEn_o=1; total latency 8 cycles.
- BEQ with taken=1, then BNE with taken=0 -> PCSrc_o=1 then 0, each with PCWrite_o=1 in EXECUTE; 3 cycles each; RegWriteEn_o never high.
- illegal_i=1 in DECODE -> state_o=7, halt_o=1, trap_cause_o=01, no further mem_req_o; rst_i clears all outputs to 0.
- MEM_TIMEOUT=4, ready held 0 in FETCH -> TRAP after 4 request cycles, cause 10; same run with ready on the 4th cycle -> DECODE, no trap.
- rst_i pulsed mid-MEM of SW (not aligned to clk) -> mem_req_o drops immediately; FETCH after release; instret_o=0; no retire.
